rand_start_scheduler: RTL
=========================

RAND_START_SCHEDULER -- requirements
Module: rand_start_scheduler

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, meaning the reset value and zero-substitute value of the LFSR.
REQ-002 SHALL have parameter GAP_BITS, default 2, meaning the width of the random idle gap between core clock enables (0..3 cycles).
REQ-003 SHALL have parameter DELAY_BITS, default 4, meaning the width of the random start delay (0..15 cycles).
REQ-004 SHALL have parameter TIMEOUT, default 4095, meaning the maximum number of cycles spent in RUN.
REQ-005 SHALL have port clk  input  1  sole clock; all state is updated on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rand_en  input  1  1 enables randomization; 0 forces all gaps and delays to zero.
REQ-008 SHALL have port seed_load  input  1  load seed_in into the LFSR.
REQ-009 SHALL have port seed_in  input  16  seed value.
REQ-010 SHALL have port start_in  input  1  start pulse from the register block.
REQ-011 SHALL have port core_busy  input  1  busy flag from the crypto core.
REQ-012 SHALL have port core_clk_en  output  1  clock enable to the crypto core.
REQ-013 SHALL have port core_load  output  1  one-cycle load strobe to the crypto core.
REQ-014 SHALL have port done_out  output  1  one-cycle completion pulse.
REQ-015 SHALL have port err_out  output  1  sticky timeout flag.
REQ-016 SHALL have port trigger_out  output  1  scope trigger, high while the operation is in progress.

Function
REQ-017 SHALL implement a 16-bit Galois LFSR with mask 16'hB400, shifting right every cycle.
REQ-018 SHALL, when seed_load=1, load seed_in into the LFSR in place of the shift, and SHALL load SEED instead if seed_in==0; seed_load SHALL be honoured in every state.
REQ-019 SHALL implement the FSM states IDLE, DELAY, LOAD, RUN and DONE.
REQ-020 SHALL, in IDLE with start_in=1, load delay_cnt with rand_en ? lfsr[DELAY_BITS-1:0] : 0, clear err_out, and go to DELAY.
REQ-021 SHALL ignore start_in in all states other than IDLE, with no queuing.
REQ-022 SHALL, in DELAY, go to LOAD when delay_cnt==0 and otherwise decrement delay_cnt, so that the delay is N+1 cycles for a loaded value N.
REQ-023 SHALL, in LOAD, assert core_load=1 and core_clk_en=1 for exactly one cycle, clear busy_seen, gap_cnt and run_cnt, and go to RUN.
REQ-024 SHALL, in RUN, drive core_clk_en=1 when gap_cnt==0, and otherwise drive 0 and decrement gap_cnt.
REQ-025 SHALL, on each RUN cycle with core_clk_en=1, reload gap_cnt with rand_en ? lfsr[GAP_BITS-1:0] : 0.
REQ-026 SHALL, in RUN, set busy_seen when core_busy=1.
REQ-027 SHALL sample core_busy for exit only on RUN cycles with core_clk_en=1.
REQ-028 SHALL go from RUN to DONE when busy_seen=1 and core_busy=0 on an enabled cycle.
REQ-029 SHALL increment run_cnt every RUN cycle, and when run_cnt reaches TIMEOUT SHALL set err_out=1 and go to DONE; the timeout SHALL take priority over a normal exit in the same cycle.
REQ-030 SHALL, in DONE, assert done_out=1 for one cycle and go to IDLE.
REQ-031 SHALL drive core_clk_en=1 in IDLE, LOAD and DONE, and 0 in DELAY.
REQ-032 SHALL drive trigger_out=1 in LOAD and RUN only.
REQ-033 SHALL make all outputs registered or decoded from state only, with no combinational path from any input to any output.

Reset
REQ-034 SHALL, on rst=1 at a clock edge, set state to IDLE, LFSR to SEED, delay_cnt, gap_cnt, run_cnt and busy_seen to 0, core_load, done_out, err_out and trigger_out to 0, and core_clk_en to 1.
REQ-035 SHALL abort any operation without emitting done_out when rst is asserted mid-operation.
REQ-036 SHALL give rst priority over seed_load and start_in.

Verification
REQ-037 SHALL be verified with rand_en=0: start_in pulse, core busy for 10 cycles starting 1 cycle after core_load -> core_load 2 cycles after start, core_clk_en constantly 1, done_out 1 cycle after busy falls, trigger_out high LOAD..RUN.
REQ-038 SHALL be verified with rand_en=1 and seed_load with seed_in=16'h0001 -> delay equals (LFSR[3:0] at start)+1 cycles, and gap lengths match a reference-model LFSR cycle by cycle.
REQ-039 SHALL be verified with seed_load and seed_in=0 -> LFSR equals 16'hACE1 on the next cycle.
REQ-040 SHALL be verified with core_busy held at 1 -> err_out=1 and done_out pulse after 4095 RUN cycles; the next start_in clears err_out.
REQ-041 SHALL be verified with start_in pulses during DELAY and RUN -> those pulses ignored and exactly one done_out produced.
REQ-042 SHALL be verified with rst asserted in RUN -> next cycle IDLE, all outputs at reset values, no done_out, core_clk_en=1.

Source files
------------

// File: rtl/rand_start_scheduler.sv
// Randomised start scheduler for a crypto core: inserts an LFSR-driven start delay
// and random idle gaps in the core clock enable, with a run timeout and scope trigger.
module rand_start_scheduler #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          GAP_BITS   = 2,
  parameter int          DELAY_BITS = 4,
  parameter int          TIMEOUT    = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rand_en,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic        start_in,
  input  logic        core_busy,
  output logic        core_clk_en,
  output logic        core_load,
  output logic        done_out,
  output logic        err_out,
  output logic        trigger_out
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0]      TIMEOUT_CNT = RUN_W'(TIMEOUT);
  localparam logic [DELAY_BITS-1:0] DELAY_ONE   = DELAY_BITS'(1);
  localparam logic [GAP_BITS-1:0]   GAP_ONE     = GAP_BITS'(1);
  localparam logic [RUN_W-1:0]      RUN_ONE     = RUN_W'(1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DELAY = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]            state;
  logic [15:0]           lfsr;
  logic [15:0]           lfsr_next;
  logic [DELAY_BITS-1:0] delay_cnt;
  logic [GAP_BITS-1:0]   gap_cnt;
  logic [RUN_W-1:0]      run_cnt;
  logic [RUN_W-1:0]      run_cnt_inc;
  logic                  busy_seen;
  logic                  gap_done;

  // Galois form, right shift: feedback taps folded in when the bit shifted out is 1.
  assign lfsr_next   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign run_cnt_inc = run_cnt + RUN_ONE;
  assign gap_done    = (gap_cnt == '0);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (seed_load) begin
      lfsr <= (seed_in == 16'h0000) ? SEED : seed_in;
    end else begin
      lfsr <= lfsr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      delay_cnt <= '0;
      gap_cnt   <= '0;
      run_cnt   <= '0;
      busy_seen <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            delay_cnt <= rand_en ? lfsr[DELAY_BITS-1:0] : '0;
            err_out   <= 1'b0;
            state     <= DELAY;
          end
        end
        DELAY: begin
          if (delay_cnt == '0) state <= LOAD;
          else                 delay_cnt <= delay_cnt - DELAY_ONE;
        end
        LOAD: begin
          busy_seen <= 1'b0;
          gap_cnt   <= '0;
          run_cnt   <= '0;
          state     <= RUN;
        end
        RUN: begin
          run_cnt <= run_cnt_inc;
          if (core_busy) busy_seen <= 1'b1;
          if (gap_done) gap_cnt <= rand_en ? lfsr[GAP_BITS-1:0] : '0;
          else          gap_cnt <= gap_cnt - GAP_ONE;
          // Timeout wins over a normal completion landing on the same cycle.
          if (run_cnt_inc == TIMEOUT_CNT) begin
            err_out <= 1'b1;
            state   <= DONE;
          end else if (gap_done && busy_seen && !core_busy) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    core_clk_en = 1'b1;
    core_load   = 1'b0;
    done_out    = 1'b0;
    trigger_out = 1'b0;
    case (state)
      DELAY: core_clk_en = 1'b0;
      LOAD: begin
        core_load   = 1'b1;
        trigger_out = 1'b1;
      end
      RUN: begin
        core_clk_en = gap_done;
        trigger_out = 1'b1;
      end
      DONE:    done_out = 1'b1;
      default: ;
    endcase
  end

endmodule
